// File: rtl/wb_arb2_rr_if.sv
// Wishbone classic bus bundle shared by the arbiter's master-facing and slave-facing ports.
// The "slave" modport is the arbiter's view of an upstream master; "master" drives the peripheral.
interface wb_arb2_rr_if #(
    parameter int WIDTH   = 8,
    parameter int ENABLES = WIDTH / 8
);
    logic               cyc;
    logic               stb;
    logic               we;
    logic [ENABLES-1:0] sel;
    logic [WIDTH-1:0]   dat_w;
    logic [WIDTH-1:0]   dat_r;
    logic               ack;
    logic               err;

    modport master (
        output cyc, stb, we, sel, dat_w,
        input  ack, err, dat_r
    );

    modport slave (
        input  cyc, stb, we, sel, dat_w,
        output ack, err, dat_r
    );
endinterface

// File: rtl/wb_arb2_rr.sv
// Two-master, one-slave Wishbone classic arbiter; round-robin, grant held for the whole cyc tenure.
// Define WB_ARB_TIMEOUT_EN to abort strobes left unanswered for TIMEOUT cycles.
module wb_arb2_rr #(
    parameter int WIDTH   = 8,
    parameter int ENABLES = WIDTH / 8,
    parameter int TIMEOUT = 15
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    wb_arb2_rr_if.slave  ma,
    wb_arb2_rr_if.slave  mb,
    wb_arb2_rr_if.master wb,
    output logic [1:0]   gnt_o
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("wb_arb2_rr: TIMEOUT must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    state_t state, state_next;
    logic   last, last_next;   // 1'b0 = A, 1'b1 = B
    logic   tmo;

    logic               cyc_m;
    logic               stb_m;
    logic               we_m;
    logic [ENABLES-1:0] sel_m;
    logic [WIDTH-1:0]   dat_m;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_next;
            last  <= last_next;
        end
    end

    always_comb begin
        state_next = state;
        last_next  = last;
        unique case (state)
            IDLE: begin
                // On a tie the master that was not served last wins
                if (ma.cyc && (!mb.cyc || last))
                    state_next = GNT_A;
                else if (mb.cyc)
                    state_next = GNT_B;
            end
            GNT_A: begin
                if (tmo) begin
                    state_next = IDLE;
                    last_next  = 1'b0;
                end else if (!ma.cyc) begin
                    state_next = mb.cyc ? GNT_B : IDLE;
                    last_next  = 1'b0;
                end
            end
            GNT_B: begin
                if (tmo) begin
                    state_next = IDLE;
                    last_next  = 1'b1;
                end else if (!mb.cyc) begin
                    state_next = ma.cyc ? GNT_A : IDLE;
                    last_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cyc_m = 1'b0;
        stb_m = 1'b0;
        we_m  = 1'b0;
        sel_m = '0;
        dat_m = '0;
        unique case (state)
            GNT_A: begin
                cyc_m = ma.cyc;
                stb_m = ma.stb;
                we_m  = ma.we;
                sel_m = ma.sel;
                dat_m = ma.dat_w;
            end
            GNT_B: begin
                cyc_m = mb.cyc;
                stb_m = mb.stb;
                we_m  = mb.we;
                sel_m = mb.sel;
                dat_m = mb.dat_w;
            end
            default: ;
        endcase
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_CNT = 8'(TIMEOUT);
    logic [7:0] stall_cnt;

    // Counts raw (unforced) stall cycles; any grant change, including the abort itself, restarts it
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            stall_cnt <= '0;
        else if (state_next != state || wb.ack)
            stall_cnt <= '0;
        else if (stb_m)
            stall_cnt <= stall_cnt + 8'd1;
    end

    assign tmo = (state != IDLE) && (stall_cnt == TMO_CNT);
`else
    assign tmo = 1'b0;
`endif

    // Abort cycle drops the bus so the slave sees the transfer withdrawn
    assign wb.cyc   = cyc_m & ~tmo;
    assign wb.stb   = stb_m & ~tmo;
    assign wb.we    = we_m;
    assign wb.sel   = sel_m;
    assign wb.dat_w = dat_m;

    assign ma.ack   = (state == GNT_A) & wb.ack & wb.stb;
    assign mb.ack   = (state == GNT_B) & wb.ack & wb.stb;
    assign ma.err   = (state == GNT_A) & tmo;
    assign mb.err   = (state == GNT_B) & tmo;
    assign ma.dat_r = wb.dat_r;
    assign mb.dat_r = wb.dat_r;

    assign gnt_o = {state == GNT_B, state == GNT_A};

endmodule

// File: doc/wb_arb2_rr.md
Name: wb_arb2_rr

Overview:
- Two-master, one-slave Wishbone classic arbiter with round-robin fairness.
- Lets two masters share one Wishbone peripheral, for example wb_leds driven by both the CPU and a debug/status master.
- Sits between the masters and the slave port. Grant is held for the whole of a master's wb_cyc tenure.
- Slave-to-master data is broadcast to both masters; ack is steered to the granted master only.

Parameters:
- WIDTH, 8, data bus width in bits. Must be a multiple of 8.
- ENABLES, WIDTH/8, number of byte-select lines.
- TIMEOUT, 15, cycles of unanswered strobe before abort. Used only with the optional feature; legal range 1..255.

Ports:
- wb_clk_i  in  1  system clock; all state updates on rising edge
- wb_rst_i  in  1  asynchronous, active-high reset
- ma_cyc_i, ma_stb_i, ma_we_i  in  1 each  master A cycle/strobe/write
- ma_sel_i  in  ENABLES  master A byte selects
- ma_dat_i  in  WIDTH  master A write data
- ma_ack_o  out  1  master A acknowledge
- ma_err_o  out  1  master A error (timeout abort)
- ma_dat_o  out  WIDTH  read data to master A
- mb_*  same set as ma_*, for master B
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  to slave
- wb_sel_o  out  ENABLES  to slave
- wb_dat_o  out  WIDTH  write data to slave
- wb_ack_i  in  1  slave acknowledge
- wb_dat_i  in  WIDTH  slave read data
- gnt_o  out  2  one-hot current grant {B,A}; 2'b00 when idle

Behaviour:
- Reset (asynchronous, active-high, any time, including mid-transfer):
  - state=IDLE, gnt_o=0, last=B.
  - All slave-side outputs 0; all ack/err outputs 0. *_dat_o may follow wb_dat_i.
  - Timeout counter cleared.
- States:
  - IDLE: no master granted.
  - GNT_A: master A owns the slave.
  - GNT_B: master B owns the slave.
- IDLE transitions, decided at the rising edge:
  - Only A requests (ma_cyc_i=1) -> GNT_A.
  - Only B requests -> GNT_B.
  - Both request -> grant goes to the master that is not `last`.
  - Grant latency: one edge from cyc assertion in IDLE to gnt_o.
- GNT_X transitions:
  - Stay while X's cyc=1, whatever the other master does.
  - At an edge where X's cyc=0: go to GNT_other if the other master's cyc=1, else IDLE.
  - Set last=X on leaving GNT_X.
  - Handover costs no idle cycle.
- Muxing while granted (combinational, from the gnt register):
  - wb_cyc_o=X.cyc, wb_stb_o=X.stb.
  - wb_we_o, wb_sel_o, wb_dat_o come from X.
  - X_ack_o=wb_ack_i & X.stb; the non-granted master's ack_o=0.
- In IDLE: wb_cyc_o=wb_stb_o=wb_we_o=0, wb_sel_o=0, wb_dat_o=0.
- Non-granted master: its stb is ignored; it waits with cyc high (standard Wishbone stall).
- Back-to-back transfers: a master keeping cyc=1 may issue any number of stb/ack transfers without re-arbitration.
- wb_ack_i arriving with wb_stb_o=0 is ignored and not forwarded.
- Simultaneous release-and-request (granted cyc falls on the same edge the other raises): handover occurs at that edge.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter increments each cycle while wb_stb_o=1 and wb_ack_i=0; it clears on ack or grant change.
  - When the count reaches TIMEOUT, assert X_err_o for exactly one cycle and force wb_cyc_o/wb_stb_o=0 for that cycle.
  - Then force the state to IDLE, set last=X, and clear the counter.
  - X must drop cyc on err; if X still requests, it re-arbitrates normally.
- Not defined: no counter is implemented; ma_err_o and mb_err_o are tied 0; the arbiter waits indefinitely.

Test Plan:
- Reset mid-transfer: GNT_A with stb high, pulse wb_rst_i for 3 ns between edges -> gnt_o, wb_cyc_o and ma_ack_o drop to 0 immediately, without waiting for a clock edge. After release, the first request is granted per last=B.
- Single master: A writes 8'hA5, sel=1 -> one edge later gnt_o=01 and wb_dat_o=A5. Slave acks next cycle -> ma_ack_o=1 for one cycle, mb_ack_o=0.
- Simultaneous requests from reset: A and B raise cyc on the same edge -> A granted first. A drops cyc -> gnt_o goes directly to 10 with no IDLE cycle. Repeat -> grants alternate A, B, A, B.
- Tenure hold: A holds cyc over 3 transfers while B requests -> gnt_o stays 01 for all three acks. B is granted on the edge where A's cyc=0. B's read returns 8'h3C on mb_dat_o with mb_ack_o=1.
- Stalled slave, macro defined, TIMEOUT=4: B strobes and the slave never acks -> mb_err_o pulses high for exactly one cycle on the 4th stall count. wb_stb_o=0 that cycle; state goes to IDLE. Without the macro, the same stimulus leaves gnt_o=10 and stb high indefinitely, with mb_err_o=0.
